hazard_detect: RTL and testbench

Producer side of the operand-forwarding interface in the 32I five-stage pipeline. Tracks the destination register and opcode of the two most recent in-flight instructions and compares them with the source registers of the instruction in ID. On each ID→EX advance it registers `is_hazard1/2`, `hazard_reg1/2` and `op` for the forwarding mux in EX. It raises `stall` for load-use and same-level dual-operand conflicts, which the mux cannot resolve.

---
 rtl/hazard_detect.sv | 123 ++++++++++++
 tb/tb_hazard_detect.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect.sv
// Tracks the two youngest in-flight writers (EX and MEM) and flags forwarding or stall for the ID instruction.
// Forward codes are registered (1-cycle latency); stall is combinational and holds IF/ID while EX takes a bubble.
module hazard_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [6:0] id_op,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       stall,
  output logic       is_hazard1,
  output logic [2:0] hazard_reg1,
  output logic       is_hazard2,
  output logic [2:0] hazard_reg2,
  output logic [6:0] op
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic writes_rd(input logic [6:0] o);
    return (o != OP_BRANCH) && (o != OP_STORE);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] o);
    return (o != OP_LUI) && (o != OP_AUIPC) && (o != OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] o);
    return (o == OP_BRANCH) || (o == OP_STORE) || (o == OP_OP);
  endfunction

  logic       n_valid_q, n_valid_d;
  logic [4:0] n_rd_q, n_rd_d;
  logic [6:0] n_op_q, n_op_d;
  logic       f_valid_q, f_valid_d;
  logic [4:0] f_rd_q, f_rd_d;
  logic [6:0] f_op_q, f_op_d;
  logic       is_hazard1_q, is_hazard1_d;
  logic [2:0] hazard_reg1_q, hazard_reg1_d;
  logic       is_hazard2_q, is_hazard2_d;
  logic [2:0] hazard_reg2_q, hazard_reg2_d;
  logic [6:0] op_q, op_d;

  logic n_wr, f_wr, nh1, nh2, fh1, fh2, stall_c, advance;

  always_comb begin
    n_wr = n_valid_q && writes_rd(n_op_q) && (n_rd_q != 5'd0);
    f_wr = f_valid_q && writes_rd(f_op_q) && (f_rd_q != 5'd0);
    nh1  = n_wr && uses_rs1(id_op) && (n_rd_q == id_rs1);
    nh2  = n_wr && uses_rs2(id_op) && (n_rd_q == id_rs2);
    // The nearer producer holds the newer value, so it masks the far one.
    fh1  = f_wr && uses_rs1(id_op) && (f_rd_q == id_rs1) && !nh1;
    fh2  = f_wr && uses_rs2(id_op) && (f_rd_q == id_rs2) && !nh2;

    stall_c = id_valid && (((n_op_q == OP_LOAD) && (nh1 || nh2)) ||
                           (nh1 && nh2) || (fh1 && fh2));
    advance = id_valid && !stall_c && !flush;

    n_valid_d = advance;
    n_rd_d    = advance ? id_rd : 5'd0;
    n_op_d    = advance ? id_op : 7'd0;
    f_valid_d = n_valid_q;
    f_rd_d    = n_rd_q;
    f_op_d    = n_op_q;

    is_hazard1_d  = 1'b0;
    hazard_reg1_d = 3'd0;
    is_hazard2_d  = 1'b0;
    hazard_reg2_d = 3'd0;
    op_d          = op_q;
    if (advance) begin
      is_hazard1_d  = nh1 || nh2;
      hazard_reg1_d = nh1 ? 3'd1 : (nh2 ? 3'd2 : 3'd0);
      is_hazard2_d  = fh1 || fh2;
      hazard_reg2_d = fh1 ? 3'd3 : (fh2 ? 3'd4 : 3'd0);
      op_d          = f_valid_q ? f_op_q : 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_valid_q     <= 1'b0;
      n_rd_q        <= 5'd0;
      n_op_q        <= 7'd0;
      f_valid_q     <= 1'b0;
      f_rd_q        <= 5'd0;
      f_op_q        <= 7'd0;
      is_hazard1_q  <= 1'b0;
      hazard_reg1_q <= 3'd0;
      is_hazard2_q  <= 1'b0;
      hazard_reg2_q <= 3'd0;
      op_q          <= 7'd0;
    end else begin
      n_valid_q     <= n_valid_d;
      n_rd_q        <= n_rd_d;
      n_op_q        <= n_op_d;
      f_valid_q     <= f_valid_d;
      f_rd_q        <= f_rd_d;
      f_op_q        <= f_op_d;
      is_hazard1_q  <= is_hazard1_d;
      hazard_reg1_q <= hazard_reg1_d;
      is_hazard2_q  <= is_hazard2_d;
      hazard_reg2_q <= hazard_reg2_d;
      op_q          <= op_d;
    end
  end

  assign stall       = stall_c;
  assign is_hazard1  = is_hazard1_q;
  assign hazard_reg1 = hazard_reg1_q;
  assign is_hazard2  = is_hazard2_q;
  assign hazard_reg2 = hazard_reg2_q;
  assign op          = op_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Directed scenarios plus randomized traffic against a pipeline-history model of hazard_detect.
module tb_hazard_detect;

  localparam logic [6:0] L_LOAD   = 7'b0000011;
  localparam logic [6:0] L_STORE  = 7'b0100011;
  localparam logic [6:0] L_BRANCH = 7'b1100011;
  localparam logic [6:0] L_OP     = 7'b0110011;
  localparam logic [6:0] L_OPIMM  = 7'b0010011;
  localparam logic [6:0] L_LUI    = 7'b0110111;
  localparam logic [6:0] L_AUIPC  = 7'b0010111;
  localparam logic [6:0] L_JAL    = 7'b1101111;
  localparam logic [6:0] L_JALR   = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       flush;
  logic       stall;
  logic       is_hazard1, is_hazard2;
  logic [2:0] hazard_reg1, hazard_reg2;
  logic [6:0] op;
  logic [14:0] outs;

  int checks = 0;
  int errors = 0;

  hazard_detect dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .stall(stall), .is_hazard1(is_hazard1), .hazard_reg1(hazard_reg1),
    .is_hazard2(is_hazard2), .hazard_reg2(hazard_reg2), .op(op)
  );

  always #5 clk = ~clk;
  assign outs = {is_hazard1, hazard_reg1, is_hazard2, hazard_reg2, op};

  // Model: history of what entered EX; pipe[0] is in EX, pipe[1] in MEM.
  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd;
  } ent_t;

  ent_t        pipe[$];
  logic [14:0] m_out;

  function automatic bit produces(ent_t e, logic [4:0] src);
    return e.v && !(e.op inside {L_BRANCH, L_STORE}) && e.rd != 5'd0 && e.rd == src;
  endfunction

  // Distance (1 = EX, 2 = MEM) of the youngest in-flight writer of a source, 0 if none.
  function automatic int src_dist(logic [4:0] r, bit used);
    if (!used) return 0;
    for (int k = 0; k < 2; k++)
      if (produces(pipe[k], r)) return k + 1;
    return 0;
  endfunction

  function automatic int dist1();
    return src_dist(id_rs1, !(id_op inside {L_LUI, L_AUIPC, L_JAL}));
  endfunction

  function automatic int dist2();
    return src_dist(id_rs2, id_op inside {L_BRANCH, L_STORE, L_OP});
  endfunction

  function automatic bit m_stall();
    int d1, d2;
    d1 = dist1();
    d2 = dist2();
    return id_valid && ((pipe[0].op == L_LOAD && (d1 == 1 || d2 == 1)) ||
                        (d1 != 0 && d1 == d2));
  endfunction

  task automatic m_reset();
    pipe  = {ent_t'(0), ent_t'(0)};
    m_out = '0;
  endtask

  task automatic m_edge();
    int d1, d2;
    bit s, go;
    logic [2:0] r1, r2;
    ent_t nw;
    d1 = dist1();
    d2 = dist2();
    s  = m_stall();
    go = !s && !flush && id_valid;
    r1 = (d1 == 1) ? 3'd1 : (d2 == 1) ? 3'd2 : 3'd0;
    r2 = (d1 == 2) ? 3'd3 : (d2 == 2) ? 3'd4 : 3'd0;
    if (go)
      m_out = {r1 != 0, r1, r2 != 0, r2, pipe[1].v ? pipe[1].op : 7'd0};
    else
      m_out = {8'd0, m_out[6:0]};
    nw   = '{v: go, op: id_op, rd: id_rd};
    pipe = {nw, pipe[0]};
  endtask

  task automatic drive(logic v, logic [6:0] o, logic [4:0] r1, logic [4:0] r2,
                       logic [4:0] rd, logic fl);
    id_valid = v; id_op = o; id_rs1 = r1; id_rs2 = r2; id_rd = rd; flush = fl;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [6:0] o, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
    drive(1'b1, o, r1, r2, rd, 1'b0);
    tick();
  endtask

  task automatic drain();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    m_reset();
    #12;
    checks++;
    if (outs !== 15'd0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_near_forward();
    drain();
    issue(L_OP, 5'd1, 5'd2, 5'd5);
    drive(1'b1, L_OP, 5'd5, 5'd7, 5'd6, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL near_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== {1'b1, 3'd1, 1'b0, 3'd0, 7'd0})
      begin errors++; $display("FAIL near_outs got %h exp %h", outs, {1'b1, 3'd1, 1'b0, 3'd0, 7'd0}); end
  endtask

  task automatic test_load_use();
    drain();
    issue(L_LOAD, 5'd1, 5'd0, 5'd5);
    drive(1'b1, L_OP, 5'd1, 5'd5, 5'd6, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_stall got %b exp 1", stall); end
    tick();
    checks++;
    if (outs[14:7] !== 8'd0) begin errors++; $display("FAIL load_bubble_outs got %h exp 0", outs[14:7]); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL load_retry_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== {1'b0, 3'd0, 1'b1, 3'd4, L_LOAD})
      begin errors++; $display("FAIL load_retry_outs got %h exp %h", outs, {1'b0, 3'd0, 1'b1, 3'd4, L_LOAD}); end
  endtask

  task automatic test_dual_operand();
    drain();
    issue(L_OPIMM, 5'd0, 5'd0, 5'd3);
    drive(1'b1, L_OP, 5'd3, 5'd3, 5'd4, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL dual_near_stall got %b exp 1", stall); end
    tick();
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL dual_far_stall got %b exp 1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL dual_third_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== 15'd0) begin errors++; $display("FAIL dual_outs got %h exp 0", outs); end
  endtask

  task automatic test_both_levels();
    drain();
    issue(L_OPIMM, 5'd0, 5'd0, 5'd1);
    issue(L_OPIMM, 5'd0, 5'd0, 5'd2);
    drive(1'b1, L_OP, 5'd2, 5'd1, 5'd9, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL both_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== {1'b1, 3'd1, 1'b1, 3'd4, L_OPIMM})
      begin errors++; $display("FAIL both_outs got %h exp %h", outs, {1'b1, 3'd1, 1'b1, 3'd4, L_OPIMM}); end
  endtask

  task automatic test_no_writer();
    drain();
    issue(L_STORE, 5'd1, 5'd2, 5'd5);
    issue(L_OPIMM, 5'd0, 5'd0, 5'd0);
    drive(1'b1, L_LUI, 5'd5, 5'd0, 5'd8, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL nowr_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== {8'd0, L_STORE}) begin errors++; $display("FAIL nowr_outs got %h exp %h", outs, {8'd0, L_STORE}); end
  endtask

  task automatic test_flush();
    drain();
    issue(L_OPIMM, 5'd0, 5'd0, 5'd5);
    drive(1'b1, L_OP, 5'd5, 5'd0, 5'd6, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs[14:7] !== 8'd0) begin errors++; $display("FAIL flush_outs got %h exp 0", outs[14:7]); end
    drive(1'b1, L_OP, 5'd5, 5'd0, 5'd6, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_retry_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== {1'b0, 3'd0, 1'b1, 3'd3, L_OPIMM})
      begin errors++; $display("FAIL flush_retry_outs got %h exp %h", outs, {1'b0, 3'd0, 1'b1, 3'd3, L_OPIMM}); end
  endtask

  task automatic test_jal_and_reset();
    drain();
    issue(L_JAL, 5'd0, 5'd0, 5'd1);
    issue(L_OPIMM, 5'd0, 5'd0, 5'd7);
    drive(1'b1, L_OP, 5'd1, 5'd0, 5'd2, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL jal_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== {1'b0, 3'd0, 1'b1, 3'd3, L_JAL})
      begin errors++; $display("FAIL jal_outs got %h exp %h", outs, {1'b0, 3'd0, 1'b1, 3'd3, L_JAL}); end
    drive(1'b1, L_OP, 5'd2, 5'd2, 5'd3, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b exp 1", stall); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL async_reset_stall got %b exp 0", stall); end
    checks++;
    if (outs !== 15'd0) begin errors++; $display("FAIL async_reset_outs got %h exp 0", outs); end
    rst_n = 1'b1;
    m_reset();
    drive(1'b1, L_OP, 5'd2, 5'd2, 5'd5, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (outs !== 15'd0) begin errors++; $display("FAIL post_reset_outs got %h exp 0", outs); end
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    bit exp_s;
    ops = '{L_LOAD, L_STORE, L_BRANCH, L_OP, L_OPIMM, L_LUI, L_AUIPC, L_JAL, L_JALR};
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 85), ops[$urandom_range(0, 8)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 10));
      #1;
      exp_s = m_stall();
      checks++;
      if (stall !== exp_s) begin errors++; $display("FAIL rand_stall[%0d] got %b exp %b", i, stall, exp_s); end
      tick();
      checks++;
      if (outs !== m_out) begin errors++; $display("FAIL rand_outs[%0d] got %h exp %h", i, outs, m_out); end
    end
  endtask

  initial begin
    test_reset();
    test_near_forward();
    test_load_use();
    test_dual_operand();
    test_both_levels();
    test_no_writer();
    test_flush();
    test_jal_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
